// File: rtl/risc8_portb_uart_rx.sv
// 8N1 serial receiver watching one risc8 port B pin; delivers each received byte
// on a valid/ready output with one-cycle framing-error and overrun pulses.
module risc8_portb_uart_rx #(
  parameter int unsigned DIVISOR = 16,
  parameter int unsigned PIN     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_b,
  input  logic [7:0] ddr_b,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned    CntW   = $clog2(DIVISOR) + 1;
  localparam logic [CntW-1:0] HalfM1 = CntW'(DIVISOR / 2 - 1);
  localparam logic [CntW-1:0] BitM1  = CntW'(DIVISOR - 1);
  localparam logic [2:0]      PinIdx = PIN[2:0];

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            sync1_q, sync2_q, rx_prev_q;
  logic            line;
  logic            rx;

  // An input-configured pin floats to the idle level.
  assign line = ddr_b[PinIdx] ? port_b[PinIdx] : 1'b1;
  assign rx   = sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= line;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (!rx && rx_prev_q) begin
          state_d = StStart;
          cnt_d   = HalfM1;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (rx) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = BitM1;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d = {rx, shift_q[7:1]};
          cnt_d   = BitM1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (rx) begin
            state_d = StIdle;
            // A byte accepted this same cycle frees the slot for the new one.
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWaitHigh: begin
        if (rx) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_risc8_portb_uart_rx.sv
// Scoreboard bench for risc8_portb_uart_rx: bit-bangs 8N1 frames on port_b[0]
// and compares delivered bytes and status pulses against expectations.
module tb_risc8_portb_uart_rx;

  localparam int Div = 16;

  logic       clk;
  logic       reset;
  logic [7:0] port_b;
  logic [7:0] ddr_b;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int         tests_run = 0;
  int         fails = 0;
  int         cyc = 0;
  int         hs_count = 0;
  int         hs_cyc = 0;
  int         fe_count = 0;
  int         ov_count = 0;
  int         stop_cyc = 0;
  logic [7:0] exp_q[$];

  risc8_portb_uart_rx #(
    .DIVISOR(Div),
    .PIN    (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .port_b   (port_b),
    .ddr_b    (ddr_b),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) begin
      logic [7:0] exp_b;
      tests_run++;
      hs_count++;
      hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got data=%02h, no byte expected", data);
      end else begin
        exp_b = exp_q.pop_front();
        if (data !== exp_b) begin
          fails++;
          $display("FAIL byte_data: got %02h, expected %02h", data, exp_b);
        end
      end
    end
    if (frame_err === 1'b1) fe_count++;
    if (overrun === 1'b1) ov_count++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    port_b[0] = 1'b0;
    tick(Div);
    for (int i = 0; i < 8; i++) begin
      port_b[0] = b[i];
      tick(Div);
    end
    stop_cyc  = cyc;
    port_b[0] = stop_bit;
    tick(Div);
  endtask

  task automatic check_count(input string name, input int got, input int want);
    tests_run++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    int valid_seen;
    reset  = 1'b0;
    port_b = 8'h00;
    ddr_b  = 8'hFF;
    ready  = 1'b1;
    tick(3);
    @(negedge clk);
    tests_run += 4;
    if (data !== 8'h00) begin
      fails++; $display("FAIL reset_data: got %02h, expected 00", data);
    end
    if (valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b, expected 0", valid);
    end
    if (frame_err !== 1'b0) begin
      fails++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err);
    end
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL reset_overrun: got %b, expected 0", overrun);
    end
    tick(1);
    port_b = 8'h01;
    tick(2);
    reset = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid !== 1'b0) valid_seen++;
    end
    check_count("idle_valid_cycles", valid_seen, 0);
    tick(1);
  endtask

  task automatic test_single_byte();
    int hs0;
    hs0   = hs_count;
    ddr_b = 8'h01;
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(20);
    check_count("single_handshakes", hs_count, hs0 + 1);
    check_count("single_latency", hs_cyc - stop_cyc, 11);
    check_count("single_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_backpressure();
    int hs0;
    int ov0;
    hs0   = hs_count;
    ov0   = ov_count;
    ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    @(negedge clk);
    tests_run += 2;
    if (valid !== 1'b1) begin
      fails++; $display("FAIL bp_valid_held: got %b, expected 1", valid);
    end
    if (data !== 8'h3C) begin
      fails++; $display("FAIL bp_data_first: got %02h, expected 3c", data);
    end
    tick(1);
    send_frame(8'h7E, 1'b1);
    tick(20);
    @(negedge clk);
    tests_run += 2;
    if (valid !== 1'b1) begin
      fails++; $display("FAIL bp_valid_after_second: got %b, expected 1", valid);
    end
    if (data !== 8'h3C) begin
      fails++; $display("FAIL bp_data_stable: got %02h, expected 3c", data);
    end
    check_count("bp_overrun_pulses", ov_count, ov0 + 1);
    tick(1);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (valid !== 1'b0) begin
      fails++; $display("FAIL bp_valid_drop: got %b, expected 0", valid);
    end
    check_count("bp_handshakes", hs_count, hs0 + 1);
    check_count("bp_queue_left", exp_q.size(), 0);
    tick(1);
  endtask

  task automatic test_frame_error();
    int hs0;
    int fe0;
    int ov0;
    hs0 = hs_count;
    fe0 = fe_count;
    ov0 = ov_count;
    send_frame(8'h55, 1'b0);
    tick(40);
    check_count("fe_pulses_while_low", fe_count, fe0 + 1);
    port_b[0] = 1'b1;
    tick(40);
    check_count("fe_pulses_total", fe_count, fe0 + 1);
    check_count("fe_no_valid", hs_count, hs0);
    check_count("fe_no_overrun", ov_count, ov0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(20);
    check_count("fe_recovery_byte", hs_count, hs0 + 1);
  endtask

  task automatic test_glitch_and_direction();
    int hs0;
    int fe0;
    hs0 = hs_count;
    fe0 = fe_count;
    port_b[0] = 1'b0;
    tick(4);
    port_b[0] = 1'b1;
    tick(40);
    check_count("glitch_no_valid", hs_count, hs0);
    check_count("glitch_no_frame_err", fe_count, fe0);
    ddr_b = 8'h00;
    send_frame(8'hFF, 1'b1);
    tick(20);
    ddr_b = 8'h01;
    tick(20);
    check_count("ddr_gated_no_valid", hs_count, hs0);
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = hs_count;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    tick(20);
    check_count("b2b_handshakes", hs_count, hs0 + 2);
    check_count("b2b_queue_left", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid_frame();
    int         hs0;
    logic [7:0] b;
    hs0 = hs_count;
    b   = 8'hC3;
    port_b[0] = 1'b0;
    tick(Div);
    for (int i = 0; i < 3; i++) begin
      port_b[0] = b[i];
      tick(Div);
    end
    port_b[0] = b[3];
    tick(Div / 2);
    reset = 1'b0;
    #1;
    tests_run += 4;
    if (data !== 8'h00) begin
      fails++; $display("FAIL midreset_data: got %02h, expected 00", data);
    end
    if (valid !== 1'b0) begin
      fails++; $display("FAIL midreset_valid: got %b, expected 0", valid);
    end
    if (frame_err !== 1'b0) begin
      fails++; $display("FAIL midreset_frame_err: got %b, expected 0", frame_err);
    end
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL midreset_overrun: got %b, expected 0", overrun);
    end
    tick(3);
    port_b[0] = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(20);
    check_count("midreset_no_valid", hs_count, hs0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    tick(20);
    check_count("midreset_recovery_byte", hs_count, hs0 + 1);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_backpressure();
    test_frame_error();
    test_glitch_and_direction();
    test_back_to_back();
    test_reset_mid_frame();
    check_count("final_queue_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/risc8_portb_uart_rx.md
Name: risc8_portb_uart_rx

Overview:
- Hardware serial receiver on the pin side of the risc8 SoC GPIO port B.
- Decodes asynchronous 8N1 frames that firmware bit-bangs on one port_b output pin.
- Delivers each byte through a valid/ready output, so benches and boards check firmware output as bytes, not raw pin traces.
- The write direction is CPU firmware driving the pin; this block is the matching reader.

Parameters:
- DIVISOR, 16: clocks per serial bit; minimum 4.
- PIN, 0: index of the port_b/ddr_b bit used as the serial line (0..7).

Ports:
- clk  input  1  system clock, same as the SoC.
- reset  input  1  asynchronous, active-low reset.
- port_b  input  8  SoC port B output latch.
- ddr_b  input  8  SoC port B direction; 1 = output.
- data  output  8  received byte, stable while valid = 1.
- valid  output  1  byte available.
- ready  input  1  consumer accepts the byte when valid && ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a byte was completed while valid = 1.

Behaviour:
- Reset (reset = 0, asynchronous) forces:
  - data = 0x00, valid = 0, frame_err = 0, overrun = 0.
  - FSM = IDLE, both synchronizer flops = 1.
- Line value:
  - line = ddr_b[PIN] ? port_b[PIN] : 1. An undriven pin is treated as idle high.
  - line passes through a 2-flop synchronizer. "rx" below means the synchronizer output.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: a cycle with rx = 0 whose previous rx = 1 is the detect cycle T0. Move to START and load the bit counter.
- START:
  - Sample rx at T0 + DIVISOR/2 (integer floor).
  - 0: go to DATA.
  - 1: glitch; return to IDLE, no outputs.
- DATA:
  - Data bit k (k = 0..7, LSB first) is sampled at T0 + DIVISOR/2 + (k+1)*DIVISOR.
  - Bits shift into an internal shift register, not into data.
- STOP: sample at T0 + DIVISOR/2 + 9*DIVISOR.
  - rx = 1 and valid = 0: next cycle data <= shift register, valid <= 1. Go to IDLE.
  - rx = 1 and valid = 1: new byte is dropped, data is unchanged, overrun pulses next cycle. Go to IDLE.
  - rx = 0: frame_err pulses next cycle, byte is discarded. Go to WAIT_HIGH.
- WAIT_HIGH: stay until rx = 1, then go to IDLE. This stops a held-low line (break) from retriggering.
- Output handshake:
  - valid stays high until a cycle with valid && ready. It drops the following cycle.
  - data does not change while valid = 1.
  - If a new byte completes in the same cycle the old one is accepted, the new byte loads and valid stays 1; no overrun.
- A new start edge is accepted in IDLE on the cycle immediately after a STOP sample. Back-to-back frames with one stop bit are received without loss.
- A ddr_b[PIN] change mid-frame is just a line level change (forced high); no special handling.
- Asserting reset mid-frame aborts the frame: no valid, no frame_err, outputs return to reset values.
- Counter width is clog2(DIVISOR) + 1 bits; no wrap within a frame.
- End-to-end latency: last pin edge of the stop bit to valid = 2 synchronizer cycles + DIVISOR/2 + 1 clocks.

Test Plan:
- Reset: hold reset = 0 with port_b = 0x00 and ddr_b = 0xFF. Expect data = 0x00, valid = 0, frame_err = 0, overrun = 0. Release reset with the line idle high: valid stays 0 for 400 cycles.
- Single byte (DIVISOR = 16, PIN = 0, ddr_b = 0x01, ready = 1):
  - Drive 0xA5 as 8N1 on port_b[0] at 16 clocks/bit.
  - Expect a one-cycle valid with data = 0xA5, 2 + 8 + 1 = 11 clocks after the stop bit starts.
- Backpressure and overrun (ready = 0):
  - Send 0x3C then 0x7E. valid stays high, data = 0x3C throughout, overrun pulses once after the second stop sample.
  - Raise ready: valid drops the next cycle.
- Framing error:
  - Send 0x55 with the stop bit low, then keep the line low for 40 cycles, then release it high.
  - Expect one frame_err pulse, no valid, and no further start detected until the line goes high.
- Glitch and direction gating:
  - A 4-cycle low pulse on port_b[0] produces no output.
  - A full 0xFF frame driven while ddr_b[0] = 0 produces no output.
  - Back-to-back 0x01, 0x80 with ready = 1 yields two valid pulses, data 0x01 then 0x80.
- Reset mid-frame: assert reset during data bit 3 of 0xC3. All outputs return to reset values immediately. A 0x12 sent after release is received correctly.
